// File: rtl/transition_counter_bank_pkg.sv
// Shared link-state encodings and default sizing for the transition counter bank.
package transition_counter_bank_pkg;
   typedef enum logic [3:0] {
      LS_DISABLED = 4'b0000,
      LS_INIT     = 4'b0001,
      LS_TRAIN    = 4'b0010,
      LS_ACTIVE   = 4'b0100,
      LS_ERROR    = 4'b1000
   } link_state_e;

   localparam int DEF_NCH    = 4;
   localparam int DEF_DATA_W = 12;
   localparam int DEF_CNT_W  = 8;
endpackage

// File: rtl/transition_counter_ch.sv
// One monitored channel: last-sample detector, transition counter and sticky overflow.
module transition_counter_ch
   import transition_counter_bank_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_init,
   input  logic              i_rd_clr,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_sat_mode,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_overflow
);
   logic [DATA_W-1:0] r_det;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ovf;
   logic              w_hit;
   logic              w_at_max;

   assign w_hit    = i_valid && (i_data != r_det);
   assign w_at_max = &r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_det <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (i_init) begin
         r_det <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_hit)
            r_det <= i_data;
         // A read-clear racing a transition keeps that transition as the new count.
         if (i_rd_clr) begin
            r_cnt <= w_hit ? CNT_W'(1) : '0;
            r_ovf <= 1'b0;
         end else if (w_hit) begin
            if (w_at_max) begin
               r_ovf <= 1'b1;
               if (!i_sat_mode)
                  r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign o_count    = r_cnt;
   assign o_overflow = r_ovf;
endmodule

// File: rtl/transition_counter_bank.sv
// Bank of NCH transition counters with a registered, optionally clearing readout port.
module transition_counter_bank
   import transition_counter_bank_pkg::*;
#(
   parameter int NCH    = DEF_NCH,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            state,
   input  logic [NCH*DATA_W-1:0] data_in,
   input  logic [NCH-1:0]        valid,
   input  logic                  sat_mode,
   input  logic                  rd_req,
   input  logic [7:0]            rd_sel,
   input  logic                  rd_clr,
   output logic [NCH*CNT_W-1:0]  counts,
   output logic [NCH-1:0]        overflow,
   output logic [CNT_W-1:0]      rd_data,
   output logic                  rd_valid,
   output logic                  rd_err
);
   logic [NCH-1:0][CNT_W-1:0] w_cnt;
   logic [CNT_W-1:0]          w_sel_cnt;
   logic                      w_init;
   logic                      w_sel_ok;
   logic [CNT_W-1:0]          r_rd_data;
   logic                      r_rd_valid;
   logic                      r_rd_err;

   assign w_init   = (state == LS_INIT);
   assign w_sel_ok = int'(rd_sel) < NCH;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      transition_counter_ch #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_ch (
         .clk        (clk),
         .reset      (reset),
         .i_init     (w_init),
         .i_rd_clr   (rd_req && rd_clr && (int'(rd_sel) == g)),
         .i_valid    (valid[g]),
         .i_data     (data_in[g*DATA_W +: DATA_W]),
         .i_sat_mode (sat_mode),
         .o_count    (w_cnt[g]),
         .o_overflow (overflow[g])
      );
   end

   always_comb begin
      w_sel_cnt = '0;
      for (int i = 0; i < NCH; i++)
         if (int'(rd_sel) == i)
            w_sel_cnt = w_cnt[i];
   end

   // Readout captures the pre-edge count, so a clear-on-read returns the old value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_rd_err   <= 1'b0;
      end else if (w_init) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_rd_err   <= 1'b0;
      end else begin
         r_rd_valid <= rd_req;
         r_rd_err   <= rd_req && !w_sel_ok;
         if (rd_req)
            r_rd_data <= w_sel_ok ? w_sel_cnt : '0;
      end
   end

   assign counts   = w_cnt;
   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;
   assign rd_err   = r_rd_err;
endmodule

// File: tb/tb_transition_counter_bank.sv
// Randomised and directed bench for transition_counter_bank with a read scoreboard.
module tb_transition_counter_bank;
   import transition_counter_bank_pkg::*;

   localparam int NCH = 4;
   localparam int DW  = 12;
   localparam int CW  = 8;
   localparam int CMOD = 1 << CW;

   logic              clk = 1'b0;
   logic              reset;
   logic [3:0]        state;
   logic [NCH*DW-1:0] data_in;
   logic [NCH-1:0]    valid;
   logic              sat_mode;
   logic              rd_req;
   logic [7:0]        rd_sel;
   logic              rd_clr;
   logic [NCH*CW-1:0] counts;
   logic [NCH-1:0]    overflow;
   logic [CW-1:0]     rd_data;
   logic              rd_valid;
   logic              rd_err;

   transition_counter_bank #(.NCH(NCH), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .state(state), .data_in(data_in), .valid(valid),
      .sat_mode(sat_mode), .rd_req(rd_req), .rd_sel(rd_sel), .rd_clr(rd_clr),
      .counts(counts), .overflow(overflow), .rd_data(rd_data),
      .rd_valid(rd_valid), .rd_err(rd_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int data;
      bit err;
   } rd_exp_t;

   rd_exp_t exp_q[$];
   int  m_det[NCH];
   int  m_cnt[NCH];
   bit  m_ovf[NCH];
   int  total = 0;
   int  bad   = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int cnt_of(input int ch);
      return int'(counts[ch*CW +: CW]);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NCH; i++) begin
         m_det[i] = 0;
         m_cnt[i] = 0;
         m_ovf[i] = 0;
      end
   endtask

   task automatic idle();
      state   = 4'(LS_ACTIVE);
      valid   = '0;
      rd_req  = 1'b0;
      rd_clr  = 1'b0;
      rd_sel  = '0;
   endtask

   task automatic set_ch(input int ch, input int v);
      data_in[ch*DW +: DW] = DW'(v);
      valid[ch] = 1'b1;
   endtask

   // Apply the currently driven inputs for one clock and compare against the model.
   task automatic tick();
      int sel;
      bit sel_ok;
      sel    = int'(rd_sel);
      sel_ok = sel < NCH;
      if (state == 4'(LS_INIT)) begin
         model_clear();
      end else begin
         if (rd_req) begin
            rd_exp_t e;
            e.data = sel_ok ? m_cnt[sel] : 0;
            e.err  = !sel_ok;
            exp_q.push_back(e);
         end
         for (int i = 0; i < NCH; i++) begin
            int  w;
            bit  tr, clr;
            w   = int'(data_in[i*DW +: DW]);
            tr  = valid[i] && (w != m_det[i]);
            clr = rd_req && rd_clr && sel_ok && (sel == i);
            if (tr) m_det[i] = w;
            if (clr) begin
               m_cnt[i] = tr ? 1 : 0;
               m_ovf[i] = 0;
            end else if (tr) begin
               if (m_cnt[i] == CMOD - 1) begin
                  m_ovf[i] = 1;
                  m_cnt[i] = sat_mode ? CMOD - 1 : 0;
               end else begin
                  m_cnt[i] = m_cnt[i] + 1;
               end
            end
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NCH; i++) begin
         check($sformatf("count[%0d]", i), cnt_of(i), m_cnt[i]);
         check($sformatf("overflow[%0d]", i), int'(overflow[i]), int'(m_ovf[i]));
      end
      idle();
   endtask

   // Monitor: every rd_valid must match the oldest outstanding request.
   always @(negedge clk) begin
      if (!reset && rd_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rd_valid", 1, 0);
         end else begin
            rd_exp_t e;
            e = exp_q.pop_front();
            check("rd_data", int'(rd_data), e.data);
            check("rd_err", int'(rd_err), int'(e.err));
         end
      end
   end

   initial begin
      reset    = 1'b1;
      data_in  = '0;
      sat_mode = 1'b0;
      idle();
      model_clear();
      #12;
      check("rst_counts", int'(counts != '0), 0);
      check("rst_overflow", int'(overflow), 0);
      check("rst_rd_valid", int'(rd_valid), 0);
      check("rst_rd_data", int'(rd_data), 0);
      @(negedge clk);
      reset = 1'b0;

      // Simple transition count on ch0
      set_ch(0, 'h000); tick();
      set_ch(0, 'h005); tick();
      set_ch(0, 'h005); tick();
      set_ch(0, 'h00A); tick();
      check("basic_ch0", cnt_of(0), 2);
      check("basic_ch1", cnt_of(1), 0);

      // Wrap then saturate on ch1
      for (int m = 0; m < 2; m++) begin
         state = 4'(LS_INIT); tick();
         sat_mode = 1'(m);
         for (int k = 0; k < 257; k++) begin
            set_ch(1, (k % 2) + 1);
            tick();
         end
         check(m ? "sat_cnt" : "wrap_cnt", cnt_of(1), m ? 255 : 1);
         check(m ? "sat_ovf" : "wrap_ovf", int'(overflow[1]), 1);
      end
      sat_mode = 1'b0;

      // Clear-on-read racing a transition on ch2
      state = 4'(LS_INIT); tick();
      for (int k = 1; k <= 7; k++) begin
         set_ch(2, k); tick();
      end
      set_ch(2, 'h100);
      rd_req = 1'b1; rd_sel = 8'd2; rd_clr = 1'b1;
      tick();
      check("clr_race_cnt", cnt_of(2), 1);
      check("clr_race_rd_valid", int'(rd_valid), 1);
      check("clr_race_rd_data", int'(rd_data), 7);

      // Out-of-range read with clear request must not disturb any channel
      rd_req = 1'b1; rd_sel = 8'd9; rd_clr = 1'b1;
      tick();
      check("oor_rd_err", int'(rd_err), 1);
      check("oor_rd_data", int'(rd_data), 0);
      tick();
      check("rd_valid_drops", int'(rd_valid), 0);

      // Overflow then INIT clears everything
      for (int k = 0; k < 260; k++) begin
         set_ch(3, k % 2 + 1); tick();
      end
      rd_req = 1'b1; rd_sel = 8'd3; tick();
      state = 4'(LS_INIT); rd_req = 1'b1; rd_sel = 8'd9; tick();
      check("init_counts", int'(counts != '0), 0);
      check("init_overflow", int'(overflow), 0);
      check("init_rd_valid", int'(rd_valid), 0);
      check("init_rd_err", int'(rd_err), 0);
      check("init_rd_data", int'(rd_data), 0);
      set_ch(3, 'h001); tick();
      check("init_first_sample", cnt_of(3), 1);

      // Randomised traffic
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < NCH; i++) begin
            data_in[i*DW +: DW] = DW'($urandom_range(0, 3));
            valid[i] = 1'($urandom_range(0, 3) != 0);
         end
         sat_mode = 1'($urandom_range(0, 1));
         rd_req   = 1'($urandom_range(0, 1));
         rd_sel   = 8'($urandom_range(0, 5));
         rd_clr   = 1'($urandom_range(0, 3) == 0);
         state    = ($urandom_range(0, 59) == 0) ? 4'(LS_INIT) : 4'(LS_TRAIN);
         tick();
      end

      // Async reset pulse between edges
      for (int k = 0; k < 5; k++) begin
         set_ch(0, k + 1); tick();
      end
      #2 reset = 1'b1;
      #1;
      check("async_rst_counts", int'(counts != '0), 0);
      check("async_rst_overflow", int'(overflow), 0);
      check("async_rst_rd_valid", int'(rd_valid), 0);
      model_clear();
      @(negedge clk);
      reset = 1'b0;
      set_ch(0, 'h001); tick();
      check("post_rst_count", cnt_of(0), 1);

      tick();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/transition_counter_bank.md
TRANSITION_COUNTER_BANK -- requirements
Module: transition_counter_bank

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent monitored channels.
REQ-002 SHALL have parameter DATA_W, default 12: width of each monitored word.
REQ-003 SHALL have parameter CNT_W, default 8: width of each transition counter.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port state, input, 4: link state; value INIT (4'b0001) is a synchronous clear.
REQ-007 SHALL have port data_in, input, NCH*DATA_W: channel i occupies bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port valid, input, NCH: per-channel sample qualifier.
REQ-009 SHALL have port sat_mode, input, 1: 1 = counters saturate, 0 = counters wrap.
REQ-010 SHALL have port rd_req, input, 1: readout request.
REQ-011 SHALL have port rd_sel, input, 8: channel index to read.
REQ-012 SHALL have port rd_clr, input, 1: clear-on-read qualifier for rd_req.
REQ-013 SHALL have port counts, output, NCH*CNT_W: live counter values, same packing as data_in.
REQ-014 SHALL have port overflow, output, NCH: sticky per-channel overflow flags.
REQ-015 SHALL have port rd_data, output, CNT_W: registered readout value.
REQ-016 SHALL have port rd_valid, output, 1: rd_data qualifier.
REQ-017 SHALL have port rd_err, output, 1: out-of-range rd_sel indicator, qualified by rd_valid.

Function
REQ-018 Each channel SHALL hold a DATA_W detector register: the last accepted sample.
REQ-019 A channel with valid[i]=1 and data word != detector SHALL increment its count and load the word into the detector.
REQ-020 A sample that is not valid, or is equal to the detector, SHALL leave count and detector unchanged.
REQ-021 After a clear the detector SHALL be 0, so a first valid nonzero sample counts as one transition.
REQ-022 In wrap mode (sat_mode=0) an increment at 2^CNT_W-1 SHALL produce 0 and set overflow[i].
REQ-023 In saturate mode (sat_mode=1) an increment at 2^CNT_W-1 SHALL hold the count and set overflow[i].
REQ-024 Either way the detector SHALL still update on an overflowing transition.
REQ-025 overflow[i] SHALL stay set until reset or state==INIT.
REQ-026 state==INIT SHALL, on the clock edge, zero all counts, detectors, overflow, rd_valid, rd_err and rd_data; it overrides all other activity.
REQ-027 On rd_req=1, rd_valid SHALL be 1 exactly one cycle later, with rd_data equal to the selected count before that edge's update.
REQ-028 rd_valid SHALL be 0 in any cycle not preceded by rd_req=1; back-to-back requests SHALL give back-to-back results.
REQ-029 rd_sel >= NCH SHALL return rd_data=0 and rd_err=1; no channel SHALL be affected.
REQ-030 rd_req with rd_clr=1 and an in-range rd_sel SHALL clear only that channel's count and overflow; its detector is kept.
REQ-031 If a transition on the cleared channel coincides with the clear, the count after the edge SHALL be 1 and rd_data SHALL be the value before the clear.
REQ-032 sat_mode changes SHALL take effect on the next increment, with no retroactive adjustment.

Reset
REQ-033 Asserting reset SHALL immediately zero counts, detectors, overflow, rd_data, rd_valid and rd_err, independent of clk.
REQ-034 Reset deassertion SHALL be synchronised by the integrator; the block SHALL count from the first edge after deassertion.

Structure
REQ-035 A shared package SHALL hold the link-state encodings (INIT=4'b0001 and the rest) and the default NCH/DATA_W/CNT_W constants.
REQ-036 One sub-module, transition_counter_ch, SHALL implement a single channel (detector, counter, overflow, clear input).
REQ-037 The top SHALL instantiate NCH transition_counter_ch copies in a generate loop and add the readout mux and registers.

Verification
REQ-038 Stimulus: reset, then ch0 valid samples 0x000, 0x005, 0x005, 0x00A. Response: counts[ch0]=2, other channels 0.
REQ-039 Stimulus: CNT_W=8, sat_mode=0, 257 alternating samples on ch1. Response: count wraps to 1 and overflow[1]=1; repeat with sat_mode=1 gives count 255 and overflow[1]=1.
REQ-040 Stimulus: ch2 count=7, then rd_req, rd_sel=2, rd_clr=1 with a transition in the same cycle. Response: next cycle rd_valid=1, rd_data=7, counts[ch2]=1.
REQ-041 Stimulus: rd_req with rd_sel=9 (NCH=4). Response: rd_valid=1, rd_err=1, rd_data=0, all counts unchanged.
REQ-042 Stimulus: nonzero counts and overflow, then state=INIT for one cycle. Response: all outputs 0; the next valid sample 0x001 gives count=1.
REQ-043 Stimulus: reset pulse asserted between clock edges mid-count. Response: outputs zero before the next clk edge.
